// File: rtl/serpent_pkg.sv
// Shared Serpent-128 types, LT constants and the LT function for the round datapath.
// Latency: combinational helpers only.
// Backpressure: none.
package serpent_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int RC_W = 6;

    localparam int LT_ROT_A = 13;
    localparam int LT_ROT_B = 3;
    localparam int LT_ROT_C = 1;
    localparam int LT_ROT_D = 7;
    localparam int LT_ROT_E = 5;
    localparam int LT_ROT_F = 22;
    localparam int LT_SHL_A = 3;
    localparam int LT_SHL_B = 7;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Operates on {w3,w2,w1,w0}; the inverse LT for decrypt will sit next to this.
    function automatic logic [127:0] serpent_lt(input logic [127:0] x);
        logic [31:0] x0, x1, x2, x3;
        x0 = x[31:0];
        x1 = x[63:32];
        x2 = x[95:64];
        x3 = x[127:96];
        x0 = rotl32(x0, LT_ROT_A);
        x2 = rotl32(x2, LT_ROT_B);
        x1 = x1 ^ x0 ^ x2;
        x3 = x3 ^ x2 ^ (x0 << LT_SHL_A);
        x1 = rotl32(x1, LT_ROT_C);
        x3 = rotl32(x3, LT_ROT_D);
        x0 = x0 ^ x1 ^ x3;
        x2 = x2 ^ x3 ^ (x1 << LT_SHL_B);
        x0 = rotl32(x0, LT_ROT_E);
        x2 = rotl32(x2, LT_ROT_F);
        return {x3, x2, x1, x0};
    endfunction

endpackage

// File: rtl/serpent_round_ctrl.sv
// Iterative Serpent-128 encryption around an external bitsliced S-box stage (SERPENT_OUT_HOLD_EN adds DONE hold).
// Latency: o_valid in the cycle after edge NUM_ROUNDS+1, edge 0 being the start-accepting edge.
// Backpressure: i_start ignored while busy; with SERPENT_OUT_HOLD_EN the result is held until i_out_ready.
module serpent_round_ctrl
    import serpent_pkg::*;
#(
    parameter int NUM_ROUNDS = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [127:0] i_block,
    output logic         o_busy,
    output logic [5:0]   o_rk_index,
    input  logic [127:0] i_rk,
    output logic [2:0]   o_sbox_index,
    output logic [31:0]  o_sbox_word_0,
    output logic [31:0]  o_sbox_word_1,
    output logic [31:0]  o_sbox_word_2,
    output logic [31:0]  o_sbox_word_3,
    input  logic [31:0]  i_sbox_word_0,
    input  logic [31:0]  i_sbox_word_1,
    input  logic [31:0]  i_sbox_word_2,
    input  logic [31:0]  i_sbox_word_3,
    input  logic         i_out_ready,
    output logic         o_valid,
    output logic [127:0] o_data
);

    localparam logic [RC_W-1:0] LAST_R = RC_W'(NUM_ROUNDS - 1);
    localparam logic [RC_W-1:0] FIN_RK = RC_W'(NUM_ROUNDS);

    state_t            state_q, state_d;
    logic [RC_W-1:0]   r_q, r_d;
    logic [127:0]      st_q, st_d;
    logic [127:0]      data_q, data_d;
    logic [127:0]      sbox_out;
    logic [127:0]      mixed;

    assign mixed    = st_q ^ i_rk;
    assign sbox_out = {i_sbox_word_3, i_sbox_word_2, i_sbox_word_1, i_sbox_word_0};

    assign {o_sbox_word_3, o_sbox_word_2, o_sbox_word_1, o_sbox_word_0} = mixed;
    assign o_sbox_index = r_q[2:0];
    assign o_busy       = (state_q != S_IDLE);
    assign o_data       = data_q;

`ifdef SERPENT_OUT_HOLD_EN
    assign o_valid = (state_q == S_DONE);
`else
    logic valid_q, valid_d;
    logic unused_out_ready;
    assign unused_out_ready = i_out_ready;
    assign o_valid = valid_q;
`endif

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        st_d       = st_q;
        data_d     = data_q;
        o_rk_index = '0;
`ifndef SERPENT_OUT_HOLD_EN
        valid_d    = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    st_d    = i_block;
                    r_d     = '0;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                o_rk_index = r_q;
                // The last S-box round skips LT; the final key XOR replaces it.
                if (r_q == LAST_R) begin
                    st_d    = sbox_out;
                    state_d = S_FINAL;
                end else begin
                    st_d = serpent_lt(sbox_out);
                    r_d  = r_q + RC_W'(1);
                end
            end
            S_FINAL: begin
                o_rk_index = FIN_RK;
                data_d     = mixed;
`ifdef SERPENT_OUT_HOLD_EN
                state_d    = S_DONE;
`else
                valid_d    = 1'b1;
                state_d    = S_IDLE;
`endif
            end
            S_DONE: begin
`ifdef SERPENT_OUT_HOLD_EN
                if (i_out_ready) state_d = S_IDLE;
`else
                state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            st_q    <= '0;
            data_q  <= '0;
`ifndef SERPENT_OUT_HOLD_EN
            valid_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            st_q    <= st_d;
            data_q  <= data_d;
`ifndef SERPENT_OUT_HOLD_EN
            valid_q <= valid_d;
`endif
        end
    end

endmodule

// File: tb/tb_serpent_round_ctrl.sv
// Bench for serpent_round_ctrl with a behavioural bitsliced S-box stage and a reference encryptor.
// Latency: checks start-to-valid timing against a cycle-stamped expectation queue.
// Backpressure: exercises ignored starts, back-to-back starts and, with SERPENT_OUT_HOLD_EN, output hold.
module tb_serpent_round_ctrl;

    localparam int N = 32;
`ifdef SERPENT_OUT_HOLD_EN
    localparam int PER = N + 3;
`else
    localparam int PER = N + 2;
`endif

    typedef struct {
        logic [127:0] data;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    exp_t         sb[$];
    logic [127:0] rk_tab[N+1];
    bit           seen = 1'b0;

    logic         start, out_ready, busy, valid;
    logic [127:0] blk, rk, data, sbi, sbo;
    logic [5:0]   rk_index;
    logic [2:0]   sbox_index;

    logic         start1, busy1, valid1;
    logic [127:0] data1, sbi1, sbo1;
    logic [5:0]   rk_index1;
    logic [2:0]   sbox_index1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] sbox_f(input logic [2:0] idx, input logic [127:0] x);
        logic [63:0]  row;
        logic [3:0]   n, v;
        logic [127:0] y;
        case (idx)
            3'd0: row = 64'hc907_24de_b56a_1f83;
            3'd1: row = 64'h43d6_8eb1_a509_72cf;
            3'd2: row = 64'h25b0_4e1d_fac3_9768;
            3'd3: row = 64'he57a_421d_369c_8bf0;
            3'd4: row = 64'hd7e9_a452_6b0c_38f1;
            3'd5: row = 64'h176d_8e30_c9a4_b25f;
            3'd6: row = 64'h0a3d_f19e_b648_5c27;
            default: row = 64'h6539_ac47_b28e_0fd1;
        endcase
        y = '0;
        for (int j = 0; j < 32; j++) begin
            n = {x[96+j], x[64+j], x[32+j], x[j]};
            v = row[4*n +: 4];
            {y[96+j], y[64+j], y[32+j], y[j]} = v;
        end
        return y;
    endfunction

    function automatic logic [31:0] rl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [127:0] ref_lt(input logic [127:0] x);
        logic [31:0] a, b, c, d;
        {d, c, b, a} = x;
        a = rl(a, 13);          c = rl(c, 3);
        b = b ^ a ^ c;          d = d ^ c ^ (a << 3);
        b = rl(b, 1);           d = rl(d, 7);
        a = a ^ b ^ d;          c = c ^ d ^ (b << 7);
        a = rl(a, 5);           c = rl(c, 22);
        return {d, c, b, a};
    endfunction

    function automatic logic [127:0] ref_enc(input logic [127:0] p);
        logic [127:0] s;
        s = p;
        for (int r = 0; r < N; r++) begin
            s = sbox_f(3'(r % 8), s ^ rk_tab[r]);
            if (r < N - 1) s = ref_lt(s);
        end
        return s ^ rk_tab[N];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    assign rk   = (rk_index <= 6'(N)) ? rk_tab[rk_index] : '0;
    assign sbi  = sbox_f(sbox_index, sbo);
    assign sbi1 = sbox_f(sbox_index1, sbo1);

    serpent_round_ctrl #(.NUM_ROUNDS(N)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_block(blk),
        .o_busy(busy), .o_rk_index(rk_index), .i_rk(rk), .o_sbox_index(sbox_index),
        .o_sbox_word_0(sbo[31:0]), .o_sbox_word_1(sbo[63:32]),
        .o_sbox_word_2(sbo[95:64]), .o_sbox_word_3(sbo[127:96]),
        .i_sbox_word_0(sbi[31:0]), .i_sbox_word_1(sbi[63:32]),
        .i_sbox_word_2(sbi[95:64]), .i_sbox_word_3(sbi[127:96]),
        .i_out_ready(out_ready), .o_valid(valid), .o_data(data)
    );

    serpent_round_ctrl #(.NUM_ROUNDS(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_block(128'h0),
        .o_busy(busy1), .o_rk_index(rk_index1), .i_rk(128'h0), .o_sbox_index(sbox_index1),
        .o_sbox_word_0(sbo1[31:0]), .o_sbox_word_1(sbo1[63:32]),
        .o_sbox_word_2(sbo1[95:64]), .o_sbox_word_3(sbo1[127:96]),
        .i_sbox_word_0(sbi1[31:0]), .i_sbox_word_1(sbi1[63:32]),
        .i_sbox_word_2(sbi1[95:64]), .i_sbox_word_3(sbi1[127:96]),
        .i_out_ready(1'b1), .o_valid(valid1), .o_data(data1)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_keys();
        for (int i = 0; i <= N; i++) rk_tab[i] = rnd128();
    endtask

    task automatic push_exp(input logic [127:0] p);
        exp_t e;
        e.data = ref_enc(p);
        e.cyc  = cyc + N + 2;
        sb.push_back(e);
    endtask

    task automatic run_block(input logic [127:0] p);
        blk   = p;
        start = 1'b1;
        push_exp(p);
        tick();
        start = 1'b0;
        for (int i = 0; i <= N; i++) begin
            chk("rk_index", 128'(rk_index), 128'(i));
            if (i < N) chk("sbox_index", 128'(sbox_index), 128'(i % 8));
            tick();
        end
        repeat (3) tick();
    endtask

    // Latency is checked on the rising valid, data on the accepting cycle.
    always @(negedge clk) begin
        if (rst_n && valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (sb.size() == 0) chk("valid_without_start", 128'(valid), 128'(0));
                else chk("valid_latency", 128'(cyc), 128'(sb[0].cyc));
            end
            if (out_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("ciphertext", data, e.data);
                seen = 1'b0;
            end
        end else if (!valid) begin
            seen = 1'b0;
        end
    end

    initial begin
        logic [127:0] b0;
        logic [127:0] hold_exp;
        rst_n = 1'b0; start = 1'b0; blk = '0; out_ready = 1'b1; start1 = 1'b0;
        new_keys();
        repeat (2) tick();
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_valid", 128'(valid), 128'(0));
        chk("rst_data", data, 128'(0));
        chk("rst_rk_index", 128'(rk_index), 128'(0));
        chk("rst_valid1", 128'(valid1), 128'(0));
        chk("rst_data1", data1, 128'(0));
        rst_n = 1'b1;
        tick();

        // Single-round instance with zero key and block.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("r1_sbox_index", 128'(sbox_index1), 128'(0));
        chk("r1_sbox_words", sbo1, 128'(0));
        chk("r1_busy", 128'(busy1), 128'(1));
        tick();
        chk("r1_valid_early", 128'(valid1), 128'(0));
        tick();
        chk("r1_valid", 128'(valid1), 128'(1));
        chk("r1_data", data1, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);
        tick();
        chk("r1_valid_pulse", 128'(valid1), 128'(0));
        chk("r1_data_hold", data1, 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF);

        // Random blocks and keys.
        for (int k = 0; k < 3; k++) begin
            new_keys();
            run_block(rnd128());
        end

        // Back-to-back with start held high.
        new_keys();
        blk   = rnd128();
        start = 1'b1;
        push_exp(blk);
        for (int k = 0; k < 3; k++) begin
            repeat (PER) tick();
            blk = rnd128();
            push_exp(blk);
        end
        tick();
        start = 1'b0;
        repeat (N + 4) tick();

        // Start pulsed mid-operation is ignored.
        b0    = rnd128();
        blk   = b0;
        start = 1'b1;
        push_exp(b0);
        tick();
        start = 1'b0;
        repeat (10) tick();
        blk   = rnd128();
        start = 1'b1;
        chk("busy_mid", 128'(busy), 128'(1));
        tick();
        start = 1'b0;
        chk("busy_after_pulse", 128'(busy), 128'(1));
        repeat (30) tick();
        chk("no_extra_block", 128'(sb.size()), 128'(0));

        // Reset at round 20 aborts without a result.
        blk   = rnd128();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_valid", 128'(valid), 128'(0));
        chk("abort_data", data, 128'(0));
        tick();
        rst_n = 1'b1;
        tick();
        run_block(rnd128());

`ifdef SERPENT_OUT_HOLD_EN
        // Output held while the consumer stalls.
        out_ready = 1'b0;
        b0        = rnd128();
        hold_exp  = ref_enc(b0);
        blk       = b0;
        start     = 1'b1;
        push_exp(b0);
        tick();
        start = 1'b0;
        repeat (N + 1) tick();
        start = 1'b1;
        blk   = rnd128();
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", 128'(valid), 128'(1));
            chk("hold_data", data, hold_exp);
            chk("hold_busy", 128'(busy), 128'(1));
            tick();
        end
        out_ready = 1'b1;
        start     = 1'b0;
        tick();
        chk("hold_release_valid", 128'(valid), 128'(0));
        chk("hold_release_busy", 128'(busy), 128'(0));
`else
        hold_exp = '0;
`endif

        repeat (5) tick();
        chk("scoreboard_empty", 128'(sb.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
